// File: rtl/hazard_pkg.sv
// hazard_pkg: shared state encoding, forwarding select codes and control bundle
// for the mMIPS hazard/forwarding unit.
`default_nettype none

package hazard_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_LU_STALL = 2'd2,
        ST_BR_FLUSH = 2'd3
    } hz_state_t;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EX  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
    localparam logic [1:0] FWD_WB  = 2'd3;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic idex_bubble;
        logic pipe_en;
        logic imem_en;
    } hz_ctrl_t;

    localparam hz_ctrl_t CTRL_OFF = '{pc_write: 1'b0, ifid_write: 1'b0, idex_bubble: 1'b1,
                                      pipe_en: 1'b0, imem_en: 1'b0};
    localparam hz_ctrl_t CTRL_RUN = '{pc_write: 1'b1, ifid_write: 1'b1, idex_bubble: 1'b0,
                                      pipe_en: 1'b1, imem_en: 1'b1};
    localparam hz_ctrl_t CTRL_LU  = '{pc_write: 1'b0, ifid_write: 1'b0, idex_bubble: 1'b1,
                                      pipe_en: 1'b1, imem_en: 1'b0};
    // Branch bubbles keep fetching so the target is prefetched during the flush.
    localparam hz_ctrl_t CTRL_BR  = '{pc_write: 1'b1, ifid_write: 1'b0, idex_bubble: 1'b1,
                                      pipe_en: 1'b1, imem_en: 1'b1};

endpackage

`default_nettype wire

// File: rtl/hazard_fwd_unit_fwd_port_sel.sv
// fwd_port_sel: priority forwarding select (EX > MEM > WB > regfile) and
// load-use flag for one decode-stage source port.
`default_nettype none

module fwd_port_sel
    import hazard_pkg::*;
#(
    parameter int RB = 5
) (
    input  logic [RB-1:0] rs,
    input  logic          used,
    input  logic          idex_regwrite,
    input  logic          idex_memread,
    input  logic [RB-1:0] idex_wreg,
    input  logic          exmem_regwrite,
    input  logic [RB-1:0] exmem_wreg,
    input  logic          memwb_regwrite,
    input  logic [RB-1:0] memwb_wreg,
    output logic [1:0]    sel,
    output logic          load_use
);

    logic ex_hit;
    logic mem_hit;
    logic wb_hit;

    // Register 0 is hardwired zero and never produces a match.
    assign ex_hit  = idex_regwrite  && (idex_wreg  == rs) && (idex_wreg  != '0);
    assign mem_hit = exmem_regwrite && (exmem_wreg == rs) && (exmem_wreg != '0);
    assign wb_hit  = memwb_regwrite && (memwb_wreg == rs) && (memwb_wreg != '0);

    always_comb begin
        sel = FWD_RF;
        if (used) begin
            if (ex_hit)       sel = FWD_EX;
            else if (mem_hit) sel = FWD_MEM;
            else if (wb_hit)  sel = FWD_WB;
        end
    end

    assign load_use = used && ex_hit && idex_memread;

endmodule

`default_nettype wire

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: per-port forwarding select, load-use stall and branch flush
// sequencing for mMIPS. Optional perf counters under `HAZARD_PERF_CNT_EN`.
`default_nettype none

module hazard_fwd_unit
    import hazard_pkg::*;
#(
    parameter int RB         = 5,
    parameter int NRD        = 2,
    parameter int BR_BUBBLES = 1,
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [NRD*RB-1:0] id_rs,
    input  logic [NRD-1:0]    id_rs_used,
    input  logic              id_branch,
    input  logic              idex_regwrite,
    input  logic              idex_memread,
    input  logic [RB-1:0]     idex_wreg,
    input  logic              exmem_regwrite,
    input  logic              exmem_memread,
    input  logic [RB-1:0]     exmem_wreg,
    input  logic              memwb_regwrite,
    input  logic [RB-1:0]     memwb_wreg,
    input  logic              dmem_wait,
    input  logic              imem_wait,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              idex_bubble,
    output logic              pipe_en,
    output logic              imem_en,
    output logic [2*NRD-1:0]  fwd_sel
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    localparam logic [2:0] BR_LOAD  = 3'(BR_BUBBLES - 1);
    localparam logic       BR_MULTI = (BR_BUBBLES > 1);

    hz_state_t        state;
    hz_state_t        state_nxt;
    logic [2:0]       br_cnt;
    logic [2:0]       br_cnt_nxt;
    logic [2*NRD-1:0] raw_sel;
    logic [NRD-1:0]   lu_port;
    logic             conflict;
    logic             wait_any;
    logic             lu_bubble;
    logic             br_bubble;
    hz_ctrl_t         ctrl;

    // EX/MEM loads are served from MEM data, so their load flag never matters here.
    logic unused_exmem_memread;
    assign unused_exmem_memread = exmem_memread;

    for (genvar k = 0; k < NRD; k++) begin : g_port
        fwd_port_sel #(
            .RB(RB)
        ) u_sel (
            .rs             (id_rs[k*RB +: RB]),
            .used           (id_rs_used[k]),
            .idex_regwrite  (idex_regwrite),
            .idex_memread   (idex_memread),
            .idex_wreg      (idex_wreg),
            .exmem_regwrite (exmem_regwrite),
            .exmem_wreg     (exmem_wreg),
            .memwb_regwrite (memwb_regwrite),
            .memwb_wreg     (memwb_wreg),
            .sel            (raw_sel[k*2 +: 2]),
            .load_use       (lu_port[k])
        );
    end

    assign conflict = |lu_port;
    assign wait_any = dmem_wait | imem_wait;
    assign fwd_sel  = (state == ST_IDLE) ? '0 : raw_sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            br_cnt <= '0;
        end else begin
            state  <= state_nxt;
            br_cnt <= br_cnt_nxt;
        end
    end

    // The detect cycle is the first branch bubble, so BR_FLUSH covers the
    // remaining BR_BUBBLES-1 cycles and leaves once the counter reaches 1.
    always_comb begin
        state_nxt  = state;
        br_cnt_nxt = br_cnt;
        if (enable && !wait_any) begin
            case (state)
                ST_IDLE: state_nxt = ST_RUN;
                ST_RUN: begin
                    if (conflict) begin
                        state_nxt = ST_LU_STALL;
                    end else if (id_branch && BR_MULTI) begin
                        state_nxt  = ST_BR_FLUSH;
                        br_cnt_nxt = BR_LOAD;
                    end
                end
                ST_LU_STALL: begin
                    if (!conflict && id_branch && BR_MULTI) begin
                        state_nxt  = ST_BR_FLUSH;
                        br_cnt_nxt = BR_LOAD;
                    end else begin
                        state_nxt = ST_RUN;
                    end
                end
                ST_BR_FLUSH: begin
                    if (br_cnt <= 3'd1) begin
                        state_nxt  = ST_RUN;
                        br_cnt_nxt = '0;
                    end else begin
                        br_cnt_nxt = br_cnt - 3'd1;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // LU_STALL evaluates like RUN: the single load-use bubble was the detect
    // cycle, and a stall is only repeated if a conflict is still visible.
    always_comb begin
        ctrl      = CTRL_OFF;
        lu_bubble = 1'b0;
        br_bubble = 1'b0;
        if (!enable) begin
            ctrl = CTRL_OFF;
        end else if (wait_any) begin
            ctrl         = CTRL_OFF;
            ctrl.imem_en = !dmem_wait;
        end else begin
            case (state)
                ST_RUN, ST_LU_STALL: begin
                    if (conflict) begin
                        ctrl      = CTRL_LU;
                        lu_bubble = 1'b1;
                    end else if (id_branch) begin
                        ctrl      = CTRL_BR;
                        br_bubble = 1'b1;
                    end else begin
                        ctrl = CTRL_RUN;
                    end
                end
                ST_BR_FLUSH: begin
                    ctrl      = CTRL_BR;
                    br_bubble = 1'b1;
                end
                default: ctrl = CTRL_OFF;
            endcase
        end
    end

    assign pc_write    = ctrl.pc_write;
    assign ifid_write  = ctrl.ifid_write;
    assign idex_bubble = ctrl.idex_bubble;
    assign pipe_en     = ctrl.pipe_en;
    assign imem_en     = ctrl.imem_en;

`ifdef HAZARD_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (lu_bubble) stall_cnt <= stall_cnt + CNT_W'(1);
            if (br_bubble) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end
`else
    logic unused_perf;
    assign unused_perf = lu_bubble ^ br_bubble;
`endif

endmodule

`default_nettype wire
